ysyx_23060042_lsu: RTL and testbench
====================================

Name: ysyx_23060042_lsu

Overview:
Load/store unit sitting between the EXU and data memory. It is the memory-side counterpart that produces the load data the EXU writes back, and accepts the store data the EXU sends. It takes one byte/half/word access per request and drives a word-addressed memory bus with a req/gnt/rvalid handshake. It returns aligned, sign- or zero-extended read data, or an error for misalignment or timeout.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before aborting with error (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EXU access request
req_ready  out  1  LSU can accept request (IDLE only)
req_addr  in  32  byte address
req_wen  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: misaligned, reserved size, or timeout
mem_req  out  1  bus request, held until mem_gnt
mem_gnt  in  1  bus accepted request this cycle
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_we  out  1  write enable
mem_wstrb  out  4  byte strobes
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid / write ack
mem_rdata  in  32  full word read data

Behaviour:
- Synchronous active-high reset; clock is clk, reset is rst.
- FSM states: IDLE, REQ, WAIT, RESP. Reset -> IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- IDLE: req_ready=1. On req_valid, latch addr, size, unsigned, wen and wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with err=1 and no bus activity.
  - Otherwise -> REQ.
- REQ: mem_req=1. mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_gnt.
  - mem_gnt=1 -> WAIT.
  - mem_gnt and mem_rvalid in the same cycle -> RESP directly, capturing mem_rdata.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in REQ, WAIT and RESP.
- Minimum latency (accept to resp_valid): 2 cycles with gnt+rvalid in the same cycle; misaligned requests also take 2.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When the counter equals TIMEOUT: -> RESP with err=1, rdata=0, mem_req dropped.
  - A late mem_rvalid in IDLE or RESP is ignored.
- Store strobes by offset o=addr[1:0]:
  - byte: wstrb=1<<o, wdata={4{wdata[7:0]}}
  - half: wstrb=4'b0011<<o, wdata={2{wdata[15:0]}}
  - word: wstrb=4'hF, wdata=wdata
  - Loads: wstrb=0, we=0.
- Load extraction: shifted = mem_rdata >> (8*o). Byte takes shifted[7:0] and half takes shifted[15:0]; each is sign- or zero-extended per req_unsigned. Word passes through unchanged.
- Stores: resp_rdata=0.
- Reset asserted mid-transaction: next edge returns to IDLE with all outputs at reset values. The in-flight bus response is dropped with no resp_valid.
- Back-to-back: a new request is accepted the cycle after the RESP pulse (IDLE).

Decomposition:
- Shared package ysyx_23060042_pkg holds:
  - lsu_size_e enum (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10)
  - lsu_state_e enum (IDLE, REQ, WAIT, RESP)
- One natural sub-module: ysyx_23060042_lsu_align. It is combinational and contains store lane/strobe generation plus load extraction and extension; the top keeps the FSM and counter.

Test Plan:
- Load byte signed, addr=0x80000003, mem_rdata=0x8F001234, gnt+rvalid same cycle -> resp_rdata=0xFFFFFF8F, err=0, resp_valid exactly 2 cycles after accept.
- Load half unsigned, addr=0x80000002, gnt 3 cycles late, rvalid 2 later, mem_rdata=0xBEEF0000 -> mem_addr=0x80000000 held stable through wait, resp_rdata=0x0000BEEF.
- Store byte, addr=0x80000001, req_wdata=0x123456AB -> mem_we=1, mem_wstrb=4'b0010, mem_wdata=0xABABABAB, resp_rdata=0.
- Misaligned load word, addr=0x80000002 -> no mem_req ever, resp_valid with err=1 two cycles after accept.
- TIMEOUT=8, mem_gnt never asserted -> mem_req high 8 cycles then low, resp_err=1, rdata=0; a later stray rvalid is ignored.
- rst pulsed while in WAIT -> next cycle req_ready=1, no resp_valid; the following load word at 0x80000004 completes normally.

Source files
------------

// File: rtl/ysyx_23060042_lsu_pkg.sv
// Shared types for the ysyx_23060042 load/store unit.
//   lsu_size_e  : access size encoding carried on req_size (2'b11 is reserved)
//   lsu_state_e : LSU control FSM states
//   access_err  : flags reserved sizes and misaligned half/word addresses
package ysyx_23060042_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } lsu_state_e;

   function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
      logic err;
      case (size)
         SZ_B:    err = 1'b0;
         SZ_H:    err = off[0];
         SZ_W:    err = (off != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/ysyx_23060042_lsu_align.sv
// Combinational lane logic for the LSU.
//   st_size/st_off/st_wdata -> st_wstrb/st_lanes : store strobes and
//                               lane-replicated store data for the bus word
//   ld_size/ld_off/ld_unsigned/ld_rdata -> ld_data : load byte/half/word
//                               extraction with sign or zero extension
module ysyx_23060042_lsu_align
   import ysyx_23060042_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_lanes,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_wstrb = '0;
      st_lanes = st_wdata;
      case (st_size)
         SZ_B: begin
            st_wstrb = 4'b0001 << st_off;
            st_lanes = {4{st_wdata[7:0]}};
         end
         SZ_H: begin
            st_wstrb = 4'b0011 << st_off;
            st_lanes = {2{st_wdata[15:0]}};
         end
         SZ_W: begin
            st_wstrb = 4'hF;
            st_lanes = st_wdata;
         end
         default: begin
            st_wstrb = '0;
            st_lanes = st_wdata;
         end
      endcase
   end

   always_comb begin
      shifted = ld_rdata >> {ld_off, 3'b000};
      case (ld_size)
         SZ_B:    ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
         SZ_H:    ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_23060042_lsu.sv
// Load/store unit between the EXU and a word-addressed data memory.
//   req_*  : one byte/half/word access per request, accepted in IDLE
//   resp_* : one-cycle completion pulse with extended load data or error
//   mem_*  : req/gnt/rvalid bus; request fields held stable until mem_gnt
// TIMEOUT bounds the cycles spent in REQ+WAIT before aborting with an error.
module ysyx_23060042_lsu
   import ysyx_23060042_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);

   lsu_state_e  state;
   logic [1:0]  lat_off;
   logic [1:0]  lat_size;
   logic        lat_uns;
   logic        lat_wen;
   logic        lat_err;
   logic [15:0] cnt;

   logic [3:0]  st_wstrb;
   logic [31:0] st_lanes;
   logic [31:0] ld_data;
   logic        timed_out;
   logic        bad_req;

   ysyx_23060042_lsu_align u_align (
      .st_size     (req_size),
      .st_off      (req_addr[1:0]),
      .st_wdata    (req_wdata),
      .st_wstrb    (st_wstrb),
      .st_lanes    (st_lanes),
      .ld_size     (lat_size),
      .ld_off      (lat_off),
      .ld_unsigned (lat_uns),
      .ld_rdata    (mem_rdata),
      .ld_data     (ld_data)
   );

   // The counter holds completed REQ/WAIT cycles; the current cycle is the
   // TIMEOUT-th one when the incremented value reaches the limit.
   assign timed_out = ({1'b0, cnt} + 17'd1) == TO_LIMIT;
   assign bad_req   = access_err(req_size, req_addr[1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wstrb  <= '0;
         mem_wdata  <= '0;
         cnt        <= '0;
         lat_off    <= '0;
         lat_size   <= '0;
         lat_uns    <= 1'b0;
         lat_wen    <= 1'b0;
         lat_err    <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_off   <= req_addr[1:0];
                  lat_size  <= req_size;
                  lat_uns   <= req_unsigned;
                  lat_wen   <= req_wen;
                  lat_err   <= bad_req;
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  state     <= REQ;
                  if (bad_req) begin
                     mem_req   <= 1'b0;
                     mem_we    <= 1'b0;
                     mem_wstrb <= '0;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_we    <= req_wen;
                     mem_wstrb <= req_wen ? st_wstrb : 4'b0000;
                     mem_wdata <= req_wen ? st_lanes : '0;
                  end
               end
            end
            REQ: begin
               // A rejected access spends its REQ cycle with the bus idle so
               // that its response lands with the same latency as a fast hit.
               if (lat_err) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else if (mem_gnt && mem_rvalid) begin
                  mem_req    <= 1'b0;
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= lat_wen ? '0 : ld_data;
               end else if (timed_out) begin
                  mem_req    <= 1'b0;
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else if (mem_gnt) begin
                  mem_req <= 1'b0;
                  cnt     <= cnt + 16'd1;
                  state   <= WAIT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= lat_wen ? '0 : ld_data;
               end else if (timed_out) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               lat_err   <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// Directed plus randomized bench for the LSU with a memory responder whose
// grant/read-valid delays are chosen per transaction.
module tb_ysyx_23060042_lsu;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wen;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ysyx_23060042_lsu #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wen      (req_wen),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_req      (mem_req),
      .mem_gnt      (mem_gnt),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access: g = cycles of mem_req before mem_gnt, r = cycles from grant
   // to mem_rvalid (0 = same cycle). Expectations come from byte arithmetic.
   task automatic run_txn(input string tag, input logic [31:0] addr, input logic wen,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int g, input int r);
      int          n, o, lat, req_cnt, wait_cnt, e_lat, e_req;
      logic        err, e_to, got, granted, stable_ok;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata, e_rdata;
      longint      v;

      o = int'(addr[1:0]);
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      err = (size == 2'd3) || ((o % n) != 0);
      e_strb = '0;
      e_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (wen && i >= o && i < o + n) e_strb[i] = 1'b1;
         e_wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
      end
      e_to = !err && (g + r + 1 > TO);
      e_lat = err ? 2 : (e_to ? TO + 1 : 2 + g + r);
      e_req = err ? 0 : ((g + 1 < TO) ? g + 1 : TO);
      v = (longint'(rdata) >> (8 * o)) % (64'sd1 << (8 * n));
      if (!uns && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
      e_rdata = (err || e_to || wen) ? 32'h0 : v[31:0];

      @(negedge clk);
      check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_addr = addr;
      req_wen = wen;
      req_size = size;
      req_unsigned = uns;
      req_wdata = wdata;
      mem_rdata = rdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;

      got = 1'b0;
      lat = 0;
      req_cnt = 0;
      wait_cnt = 0;
      granted = 1'b0;
      stable_ok = 1'b1;
      for (int cyc = 1; cyc <= TO + 6 && !got; cyc++) begin
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (resp_valid) begin
            got = 1'b1;
            lat = cyc;
         end else begin
            if (mem_req) begin
               req_cnt++;
               if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== wen || mem_wstrb !== e_strb)
                  stable_ok = 1'b0;
               if (wen && mem_wdata !== e_wdata) stable_ok = 1'b0;
               if (req_cnt == g + 1) begin
                  mem_gnt = 1'b1;
                  granted = 1'b1;
                  if (r == 0) mem_rvalid = 1'b1;
               end
            end else if (granted) begin
               wait_cnt++;
               if (wait_cnt == r) mem_rvalid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
         end
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      check({tag, ":resp_seen"}, {31'b0, got}, 32'd1);
      check({tag, ":latency"}, lat, e_lat);
      check({tag, ":err"}, {31'b0, resp_err}, {31'b0, err | e_to});
      check({tag, ":rdata"}, resp_rdata, e_rdata);
      check({tag, ":req_cycles"}, req_cnt, e_req);
      check({tag, ":bus_fields"}, {31'b0, stable_ok}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check({tag, ":pulse_len"}, {31'b0, resp_valid}, 32'd0);
      check({tag, ":ready_after"}, {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      req_wen = 1'b0;
      req_size = '0;
      req_unsigned = 1'b0;
      req_wdata = '0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst:req_ready", {31'b0, req_ready}, 32'd1);
      check("rst:resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst:resp_rdata", resp_rdata, 32'd0);
      check("rst:resp_err", {31'b0, resp_err}, 32'd0);
      check("rst:mem_req", {31'b0, mem_req}, 32'd0);
      check("rst:mem_we", {31'b0, mem_we}, 32'd0);
      check("rst:mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
      check("rst:mem_addr", mem_addr, 32'd0);
      check("rst:mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;

      run_txn("lb_signed", 32'h8000_0003, 1'b0, 2'd0, 1'b0, 32'h0, 32'h8F00_1234, 0, 0);
      check("lb_signed:value", resp_rdata, 32'h0);
      run_txn("lhu_late", 32'h8000_0002, 1'b0, 2'd1, 1'b1, 32'h0, 32'hBEEF_0000, 3, 2);
      run_txn("sb", 32'h8000_0001, 1'b1, 2'd0, 1'b0, 32'h1234_56AB, 32'hDEAD_BEEF, 0, 0);
      run_txn("lw_misalign", 32'h8000_0002, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 0, 0);
      run_txn("size_rsvd", 32'h8000_0000, 1'b1, 2'd3, 1'b0, 32'h5555_AAAA, 32'h0, 0, 0);
      run_txn("timeout", 32'h8000_0010, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1000, 0);

      // Stray read-valid after the timed-out access must not produce a response.
      for (int k = 0; k < 3; k++) begin
         mem_rvalid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("stray_rvalid", {31'b0, resp_valid}, 32'd0);
      end
      mem_rvalid = 1'b0;

      // Reset while waiting for read data.
      @(negedge clk);
      req_valid = 1'b1;
      req_addr = 32'h8000_0008;
      req_wen = 1'b0;
      req_size = 2'd2;
      req_unsigned = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid:mem_req", {31'b0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_gnt = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rstmid:ready", {31'b0, req_ready}, 32'd1);
      check("rstmid:resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rstmid:mem_req_low", {31'b0, mem_req}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata = 32'h7777_7777;
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rstmid:dropped", {31'b0, resp_valid}, 32'd0);
      run_txn("lw_after_rst", 32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'h0, 32'h89AB_CDEF, 0, 1);

      for (int t = 0; t < 30; t++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         a = $urandom;
         sz = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         run_txn("rand", a, 1'($urandom), sz, 1'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
